// File: rtl/gate_truth_sequencer_pkg.sv
// Shared FSM state encodings, reference truth tables for the lab gates, and timer sizing.
package gate_truth_sequencer_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // Bit i is the expected gate output for input vector i (bit 0 = a, bit 1 = b).
  localparam logic [3:0] TT_NAND2 = 4'b0111;
  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_XOR2  = 4'b0110;

  // Down-counter width able to hold SETTLE-1; never narrower than one bit.
  function automatic int timer_width(input int settle);
    return (settle > 1) ? $clog2(settle) : 1;
  endfunction

endpackage

// File: rtl/gate_truth_sequencer_if.sv
// Board/gate-facing bundle of the sequencer: start request, gate vector/output, and sweep results.
interface gate_truth_sequencer_if #(
  parameter int N_IN = 2
);

  logic            start;
  logic [N_IN-1:0] vec;
  logic            x;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_cnt;
  logic [N_IN-1:0] fail_idx;
  logic            fail_vld;

  modport master (
    input  start, x,
    output vec, busy, done, pass, err_cnt, fail_idx, fail_vld
  );

  modport slave (
    output start, x,
    input  vec, busy, done, pass, err_cnt, fail_idx, fail_vld
  );

endinterface

// File: rtl/gate_truth_sequencer_settle_timer.sv
// Loadable down-counter holding each vector for a fixed number of cycles; zero flags expiry.
module settle_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gate_truth_sequencer.sv
// Sweeps every input vector of a small gate in ascending order and checks the output against TRUTH.
// Accepted start to done takes 1 + 2**N_IN*(SETTLE+1) cycles; start is ignored while a sweep runs.
module gate_truth_sequencer
  import gate_truth_sequencer_pkg::*;
#(
  parameter int                     N_IN   = 2,
  parameter int                     SETTLE = 2,
  parameter logic [(1<<N_IN)-1:0]   TRUTH  = 4'b0111
) (
  input logic                    clk,
  input logic                    rst,
  gate_truth_sequencer_if.master bus
);

  localparam int            TW     = timer_width(SETTLE);
  localparam logic [TW-1:0] RELOAD = TW'(SETTLE - 1);

  logic [1:0]      state;
  logic [N_IN-1:0] vec_q;
  logic [N_IN-1:0] fail_idx_q;
  logic [N_IN:0]   err_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic            fail_vld_q;

  logic accept;
  logic last_vec;
  logic mismatch;
  logic timer_load;
  logic timer_dec;
  logic timer_zero;

  assign accept     = bus.start && (state == S_IDLE || state == S_DONE);
  assign last_vec   = (vec_q == {N_IN{1'b1}});
  assign mismatch   = (bus.x != TRUTH[vec_q]);
  assign timer_load = accept || (state == S_SAMPLE && !last_vec);
  assign timer_dec  = (state == S_SETTLE) && !timer_zero;

  settle_timer #(
    .W (TW)
  ) u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (RELOAD),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      vec_q      <= '0;
      err_q      <= '0;
      fail_idx_q <= '0;
      fail_vld_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            state      <= S_SETTLE;
            vec_q      <= '0;
            err_q      <= '0;
            fail_idx_q <= '0;
            fail_vld_q <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (timer_zero) begin
            state <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          if (mismatch) begin
            err_q <= err_q + (N_IN+1)'(1);
            if (!fail_vld_q) begin
              fail_idx_q <= vec_q;
              fail_vld_q <= 1'b1;
            end
          end
          // pass must include this final comparison, which err_q has not absorbed yet
          if (last_vec) begin
            state  <= S_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= (err_q == '0) && !mismatch;
          end else begin
            vec_q <= vec_q + N_IN'(1);
            state <= S_SETTLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.vec      = vec_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.err_cnt  = err_q;
  assign bus.fail_idx = fail_idx_q;
  assign bus.fail_vld = fail_vld_q;

endmodule
